ex_div_unit: RTL and testbench

Iterative 32-bit radix-2 divider in the EX stage. It is the requester side of the pipeline stall handshake. While a DIV/DIVU is in progress it holds `stallreq_for_ex` high, so the stall controller freezes PC through EX. It releases the request in the cycle the quotient and remainder become valid for HI/LO writeback.

---
 rtl/ex_div_unit.sv | 130 +++++++++++++
 tb/tb_ex_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
//------------------------------------------------------------------------------
// Module   : ex_div_unit
// Brief    : Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the EX
//            stage, raising a pipeline stall request while a divide is running.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_en,
    input  logic        signed_div,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stallreq_for_ex,
    output logic        result_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] C_LAST_STEP = 6'd31;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_qsign;
    logic        r_rsign;

    logic        w_accept;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;

    assign w_accept = (r_state == S_IDLE) & div_en & ~flush;
    assign w_abs_rs = (signed_div & rs_data[31]) ? -rs_data : rs_data;
    assign w_abs_rt = (signed_div & rt_data[31]) ? -rt_data : rt_data;

    // Remainder stays below the divisor, so its 33rd bit is only needed in
    // the shifted trial value; a borrow shows up as bit 32 of the difference.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_trial  = w_shift - {1'b0, r_dvsr};
    assign w_rem_nx = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
    assign w_quo_nx = {r_quo[30:0], ~w_trial[32]};

    always_comb begin
        w_next          = r_state;
        stallreq_for_ex = 1'b0;
        result_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stallreq_for_ex = 1'b1;
                    w_next          = (rt_data == 32'd0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    stallreq_for_ex = 1'b1;
                    if (r_cnt == C_LAST_STEP) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_dvsr  <= 32'd0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rem   <= 32'd0;
                r_quo   <= w_abs_rs;
                r_dvsr  <= w_abs_rt;
                r_qsign <= (rs_data[31] ^ rt_data[31]) & signed_div;
                r_rsign <= rs_data[31] & signed_div;
                r_cnt   <= 6'd0;
                if (rt_data == 32'd0) begin
                    hi_o <= rs_data;
                    lo_o <= 32'hFFFF_FFFF;
                end
            end else if ((r_state == S_BUSY) && !flush) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 6'd1;
                // Final step: sign-correct straight into the output registers.
                if (r_cnt == C_LAST_STEP) begin
                    lo_o <= r_qsign ? -w_quo_nx : w_quo_nx;
                    hi_o <= r_rsign ? -w_rem_nx : w_rem_nx;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_div_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_div_unit
// Brief    : Self-checking bench for ex_div_unit against a cycle-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_en;
    logic        signed_div;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stallreq_for_ex;
    logic        result_valid;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_vec = 0;
    int n_err = 0;

    // Model state: remaining BUSY cycles, DONE flag, expected output registers.
    int          m_busy;
    bit          m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;

    ex_div_unit dut (
        .clk             (clk),
        .rst             (rst),
        .div_en          (div_en),
        .signed_div      (signed_div),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .flush           (flush),
        .stallreq_for_ex (stallreq_for_ex),
        .result_valid    (result_valid),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(bit s, logic [31:0] a, logic [31:0] b);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy > 0) begin
            if (flush) begin
                m_busy = 0;
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_done = 1'b1;
                    m_hi   = m_phi;
                    m_lo   = m_plo;
                end
            end
        end else if (div_en && !flush) begin
            {m_phi, m_plo} = ref_div(signed_div, rs_data, rt_data);
            if (rt_data == 32'd0) begin
                m_done = 1'b1;
                m_hi   = m_phi;
                m_lo   = m_plo;
            end else begin
                m_busy = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("stall", 32'(stallreq_for_ex),
                32'(((m_busy == 0) && !m_done && div_en && !flush) || ((m_busy > 0) && !flush)));
            chk("valid", 32'(result_valid), 32'(m_done));
            chk("hi", hi_o, m_hi);
            chk("lo", lo_o, m_lo);
        end
    end

    // Issue one divide starting in the current cycle; returns just after the
    // edge that ends the DONE cycle, so a following call is back-to-back.
    task automatic run_div(string name, bit s, logic [31:0] a, logic [31:0] b,
                           logic [31:0] exp_lo, logic [31:0] exp_hi, int exp_lat);
        int lat;
        div_en     = 1'b1;
        signed_div = s;
        rs_data    = a;
        rt_data    = b;
        lat        = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (result_valid) break;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " lo"}, lo_o, exp_lo);
        chk({name, " hi"}, hi_o, exp_hi);
        @(posedge clk);
        #1;
        div_en = 1'b0;
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        div_en     = 1'b0;
        signed_div = 1'b0;
        flush      = 1'b0;
        rs_data    = 32'd0;
        rt_data    = 32'd0;
        @(posedge clk);
        #1;
        chk("reset stall", 32'(stallreq_for_ex), 32'd0);
        chk("reset valid", 32'(result_valid), 32'd0);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("divu 100/7",     1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33);
        run_div("div -7/2",       1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("divu by zero",   1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1);
        run_div("div overflow",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33);
        run_div("divu 8000/ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33);
        run_div("div -100/7",     1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
        run_div("div 100/-7",     1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         33);
        run_div("div by zero",    1'b1, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF9C, 1);

        // Flush at T+10: stall drops that cycle, no result afterwards.
        @(posedge clk);
        #1;
        div_en     = 1'b1;
        signed_div = 1'b0;
        rs_data    = 32'd50;
        rt_data    = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush  = 1'b1;
        div_en = 1'b0;
        @(negedge clk);
        chk("flush stall drop", 32'(stallreq_for_ex), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        chk("flush no valid", 32'(seen), 32'd0);
        chk("flush hi held", hi_o, 32'hFFFF_FF9C);
        chk("flush lo held", lo_o, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Asynchronous reset in the middle of a divide.
        div_en     = 1'b1;
        signed_div = 1'b0;
        rs_data    = 32'd100;
        rt_data    = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        rst    = 1'b1;
        div_en = 1'b0;
        #1;
        chk("async rst stall", 32'(stallreq_for_ex), 32'd0);
        chk("async rst valid", 32'(result_valid), 32'd0);
        chk("async rst hi", hi_o, 32'd0);
        chk("async rst lo", lo_o, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_div("divu ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
